// File: rtl/ped_pkg.sv
// Shared types and default timing constants for the pedestrian request controller.
package ped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WALK     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_COOLDOWN = 3'd5
  } ped_state_t;

  localparam int unsigned WALK_CYCLES_DEF  = 16;
  localparam int unsigned CLEAR_CYCLES_DEF = 8;
  localparam int unsigned FLASH_DIV_DEF    = 2;
  localparam int unsigned MIN_GAP_DEF      = 4;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  function automatic int unsigned ped_max4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ped_sync.sv
// Multi-flop synchronizer for asynchronous level inputs; chain clears to 0 on reset.
module ped_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) chain_q <= '0;
    else         chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian-side initiator of the 4-phase req/grant crossing handshake:
// button sync + edge detect, request, WALK, flashing CLEAR, release and cooldown.
module ped_request_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = WALK_CYCLES_DEF,
  parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int unsigned FLASH_DIV    = FLASH_DIV_DEF,
  parameter int unsigned MIN_GAP      = MIN_GAP_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic clk_ped,
  input  logic rst_ped_n,
  input  logic button,
  input  logic grant_async,
  output logic req,
  output logic walk,
  output logic waiting,
  output logic busy
);

  localparam int unsigned CMAX = ped_max4(WALK_CYCLES, CLEAR_CYCLES, FLASH_DIV, MIN_GAP);
  localparam int          CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] FDIV_LOAD  = CW'(FLASH_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(MIN_GAP - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic button_s, grant_s, btn_q, press;

  ped_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fdiv_q, fdiv_d;
  logic          flash_q, flash_d;
  logic          pending_q, pending_d;
  logic          req_q, req_d, walk_q, walk_d, waiting_q, waiting_d, busy_q, busy_d;

  ped_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_button (
    .clk_i (clk_ped),
    .rst_ni(rst_ped_n),
    .d_i   (button),
    .q_o   (button_s)
  );

  ped_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_grant (
    .clk_i (clk_ped),
    .rst_ni(rst_ped_n),
    .d_i   (grant_async),
    .q_o   (grant_s)
  );

  assign press = button_s & ~btn_q;

  always_ff @(posedge clk_ped) begin
    if (!rst_ped_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fdiv_q    <= '0;
      flash_q   <= 1'b0;
      pending_q <= 1'b0;
      btn_q     <= 1'b0;
      req_q     <= 1'b0;
      walk_q    <= 1'b0;
      waiting_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fdiv_q    <= fdiv_d;
      flash_q   <= flash_d;
      pending_q <= pending_d;
      btn_q     <= button_s;
      req_q     <= req_d;
      walk_q    <= walk_d;
      waiting_q <= waiting_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fdiv_d    = fdiv_q;
    flash_d   = flash_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (press || pending_q) begin
          state_d   = ST_REQ;
          pending_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (grant_s) begin
          state_d = ST_WALK;
          cnt_d   = WALK_LOAD;
        end
      end
      ST_WALK: begin
        // A dropped grant is a traffic abort and beats counter expiry.
        if (!grant_s) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == '0) begin
          state_d = ST_CLEAR;
          cnt_d   = CLEAR_LOAD;
          flash_d = 1'b1;
          fdiv_d  = FDIV_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_CLEAR: begin
        if (!grant_s || cnt_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - ONE;
          if (fdiv_q == '0) begin
            flash_d = ~flash_q;
            fdiv_d  = FDIV_LOAD;
          end else begin
            fdiv_d = fdiv_q - ONE;
          end
        end
      end
      ST_RELEASE: begin
        if (!grant_s) begin
          state_d = ST_COOLDOWN;
          cnt_d   = GAP_LOAD;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - ONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Presses while the crossing is in progress coalesce into one follow-up request.
    if (press && (state_q == ST_WALK || state_q == ST_CLEAR ||
                  state_q == ST_RELEASE || state_q == ST_COOLDOWN))
      pending_d = 1'b1;
  end

  // Outputs derive from the next state so they switch on the same edge as the state.
  always_comb begin
    req_d     = (state_d == ST_REQ) || (state_d == ST_WALK) || (state_d == ST_CLEAR);
    walk_d    = (state_d == ST_WALK) || ((state_d == ST_CLEAR) && flash_d);
    waiting_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
  end

  assign req     = req_q;
  assign walk    = walk_q;
  assign waiting = waiting_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl; outputs viewed as {req,walk,waiting,busy}.
module tb_ped_request_ctrl;

  logic clk_ped = 1'b0;
  logic rst_ped_n = 1'b0;
  logic button = 1'b0;
  logic grant_async = 1'b0;
  logic req, walk, waiting, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk_ped = ~clk_ped;

  ped_request_ctrl dut (
    .clk_ped    (clk_ped),
    .rst_ped_n  (rst_ped_n),
    .button     (button),
    .grant_async(grant_async),
    .req        (req),
    .walk       (walk),
    .waiting    (waiting),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk_ped);
    #1;
  endtask

  task automatic test_reset();
    rst_ped_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 0000", {req, walk, waiting, busy});
    end
    rst_ped_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got %b expected 0000", i, {req, walk, waiting, busy});
      end
    end
  endtask

  task automatic test_stale_grant();
    grant_async = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL stale_grant[%0d]: got %b expected 0000", i, {req, walk, waiting, busy});
      end
    end
    grant_async = 1'b0;
    repeat (4) tick();
  endtask

  task automatic full_cycle(input string tag);
    logic [7:0] flash_exp;
    flash_exp = 8'b0011_0011;
    button = 1'b1;
    tick();
    button = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_press_lat1: got busy=%b expected 0", tag, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_press_lat2: got busy=%b expected 0", tag, busy);
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL %s_req_rise: got %b expected 1011", tag, {req, walk, waiting, busy});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b1011) begin
        errors++;
        $display("FAIL %s_req_hold[%0d]: got %b expected 1011", tag, i, {req, walk, waiting, busy});
      end
    end
    grant_async = 1'b1;
    tick();
    tick();
    checks++;
    if (walk !== 1'b0) begin
      errors++;
      $display("FAIL %s_walk_early: got walk=%b expected 0", tag, walk);
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL %s_walk_rise: got %b expected 1101", tag, {req, walk, waiting, busy});
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b1101) begin
        errors++;
        $display("FAIL %s_walk_steady[%0d]: got %b expected 1101", tag, i, {req, walk, waiting, busy});
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== {1'b1, flash_exp[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL %s_clear_flash[%0d]: got %b expected %b", tag, i,
                 {req, walk, waiting, busy}, {1'b1, flash_exp[i], 1'b0, 1'b1});
      end
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL %s_release: got %b expected 0001", tag, {req, walk, waiting, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL %s_release_hold[%0d]: got %b expected 0001", tag, i, {req, walk, waiting, busy});
      end
    end
    grant_async = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL %s_cooldown[%0d]: got %b expected 0001", tag, i, {req, walk, waiting, busy});
      end
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_idle_return: got %b expected 0000", tag, {req, walk, waiting, busy});
    end
  endtask

  task automatic test_no_rerequest();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL no_rerequest[%0d]: got %b expected 0000", i, {req, walk, waiting, busy});
      end
    end
  endtask

  task automatic test_pending();
    int n;
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL pend_req: got %b expected 1011", {req, walk, waiting, busy});
    end
    grant_async = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL pend_walk: got %b expected 1101", {req, walk, waiting, busy});
    end
    for (int k = 0; k < 3; k++) begin
      button = 1'b1;
      tick();
      button = 1'b0;
      tick();
    end
    n = 0;
    while (req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 18) begin
      errors++;
      $display("FAIL pend_walk_clear_len: got %0d cycles expected 18", n);
    end
    grant_async = 1'b0;
    repeat (6) tick();
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL pend_idle_gap: got %b expected 0000", {req, walk, waiting, busy});
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL pend_auto_req: got %b expected 1011", {req, walk, waiting, busy});
    end
    grant_async = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL pend_walk2: got %b expected 1101", {req, walk, waiting, busy});
    end
    n = 0;
    while (req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL pend_walk2_len: got %0d cycles expected 24", n);
    end
    grant_async = 1'b0;
    repeat (7) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL pend_single_extra[%0d]: got %b expected 0000", i, {req, walk, waiting, busy});
      end
    end
  endtask

  task automatic test_abort();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    tick();
    grant_async = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL abort_walk: got %b expected 1101", {req, walk, waiting, busy});
    end
    repeat (5) tick();
    grant_async = 1'b0;
    tick();
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL abort_sync_lat: got %b expected 1101", {req, walk, waiting, busy});
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_release: got %b expected 0001", {req, walk, waiting, busy});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL abort_cooldown[%0d]: got %b expected 0001", i, {req, walk, waiting, busy});
      end
    end
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got %b expected 0000", {req, walk, waiting, busy});
    end
  endtask

  task automatic test_reset_mid();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    tick();
    grant_async = 1'b1;
    repeat (3) tick();
    repeat (16) tick();
    repeat (2) tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL rstmid_in_clear: got %b expected 1001", {req, walk, waiting, busy});
    end
    rst_ped_n = 1'b0;
    tick();
    checks++;
    if ({req, walk, waiting, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b expected 0000", {req, walk, waiting, busy});
    end
    grant_async = 1'b0;
    tick();
    rst_ped_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req, walk, waiting, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL rstmid_idle[%0d]: got %b expected 0000", i, {req, walk, waiting, busy});
      end
    end
    full_cycle("post_rst");
  endtask

  initial begin
    test_reset();
    test_stale_grant();
    full_cycle("basic");
    test_no_rerequest();
    test_pending();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
